// File: rtl/execute_stage_if.sv
// Handshake and datapath bundle between decode/register-read, the execute
// stage, and memory/writeback.
interface execute_stage_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned INST_W = 64
);
    logic              i_valid;
    logic              o_ready;
    logic [INST_W-1:0] Single_Instruction_i;
    logic [XLEN-1:0]   i_rs1;
    logic [XLEN-1:0]   i_rs2;
    logic [XLEN-1:0]   i_imm;
    logic [XLEN-1:0]   i_pc;
    logic [4:0]        i_rd;
    logic              i_flush;
    logic              i_ready;
    logic              o_valid;
    logic [XLEN-1:0]   o_result;
    logic [4:0]        o_rd;
    logic              o_we;
    logic              o_br_taken;
    logic [XLEN-1:0]   o_br_target;
    logic [XLEN-1:0]   o_mem_wdata;
    logic              o_illegal;
    logic [31:0]       o_retired;

    modport slave (
        input  i_valid, Single_Instruction_i, i_rs1, i_rs2, i_imm, i_pc, i_rd,
               i_flush, i_ready,
        output o_ready, o_valid, o_result, o_rd, o_we, o_br_taken, o_br_target,
               o_mem_wdata, o_illegal, o_retired
    );

    modport master (
        output i_valid, Single_Instruction_i, i_rs1, i_rs2, i_imm, i_pc, i_rd,
               i_flush, i_ready,
        input  o_ready, o_valid, o_result, o_rd, o_we, o_br_taken, o_br_target,
               o_mem_wdata, o_illegal, o_retired
    );
endinterface

// File: rtl/execute_stage.sv
// RV32I execute stage: ALU, branch resolution and address generation behind a
// valid/ready handshake, with an optional iterative shifter and retire counter.
module execute_stage #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned INST_W       = 64,
    parameter int unsigned SERIAL_SHIFT = 1,
    parameter int unsigned SHIFT_STEP   = 4
) (
    input logic            i_clk,
    input logic            i_rst,
    execute_stage_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shkind_t;

    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    state_t            state_q, state_d;
    shkind_t           kind_q, kind_d, kind_dec;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_q, rd_d;
    logic              we_q, we_d;
    logic              taken_q, taken_d;
    logic [XLEN-1:0]   target_q, target_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              illegal_q, illegal_d;
    logic [31:0]       retired_q, retired_d;
    logic [4:0]        rem_q, rem_d;

    logic [INST_W-1:0] inst;
    logic              illegal, is_shift, use_imm, serial, lt_s, lt_u, taken, we;
    logic [XLEN-1:0]   op2, sum, pc_imm, alu, target, shifted;
    logic [4:0]        shamt, step;
    logic              ready, accept;

    // Decode and single-cycle datapath
    always_comb begin
        inst     = bus.Single_Instruction_i;
        illegal  = !$onehot(inst) || inst[0] || inst[38] || inst[39] ||
                   (|inst[47:42]) || ((inst >> 48) != '0);
        is_shift = inst[6] | inst[7] | inst[8] | inst[15] | inst[16] | inst[17];
        use_imm  = (|inst[27:11]) | inst[35] | inst[36];
        op2      = use_imm ? bus.i_imm : bus.i_rs2;
        shamt    = op2[4:0];
        sum      = bus.i_rs1 + op2;
        pc_imm   = bus.i_pc + bus.i_imm;
        lt_s     = $signed(bus.i_rs1) < $signed(op2);
        lt_u     = bus.i_rs1 < op2;
        serial   = (SERIAL_SHIFT != 0) && is_shift && (shamt != '0);
        kind_dec = (inst[6] | inst[15]) ? SH_LL : ((inst[8] | inst[17]) ? SH_RA : SH_RL);

        alu = '0;
        if (inst[1] | inst[11])        alu = sum;
        else if (inst[2])              alu = bus.i_rs1 - op2;
        else if (inst[3] | inst[12])   alu = bus.i_rs1 ^ op2;
        else if (inst[4] | inst[13])   alu = bus.i_rs1 | op2;
        else if (inst[5] | inst[14])   alu = bus.i_rs1 & op2;
        else if (inst[6] | inst[15])   alu = bus.i_rs1 << shamt;
        else if (inst[7] | inst[16])   alu = bus.i_rs1 >> shamt;
        else if (inst[8] | inst[17])   alu = $signed(bus.i_rs1) >>> shamt;
        else if (inst[9] | inst[18])   alu = XLEN'(lt_s);
        else if (inst[10] | inst[19])  alu = XLEN'(lt_u);
        else if (|inst[27:20])         alu = sum;
        else if (inst[34] | inst[35])  alu = bus.i_pc + XLEN'(4);
        else if (inst[36])             alu = bus.i_imm;
        else if (inst[37])             alu = pc_imm;

        taken = (inst[28] && bus.i_rs1 == op2) || (inst[29] && bus.i_rs1 != op2) ||
                (inst[30] && lt_s) || (inst[31] && !lt_s) ||
                (inst[32] && lt_u) || (inst[33] && !lt_u) || inst[34] || inst[35];
        target = inst[35] ? (sum & ~XLEN'(1)) : pc_imm;
        we     = !((|inst[33:25]) | inst[40] | inst[41]) && (bus.i_rd != '0);

        if (illegal) begin
            alu   = '0;
            taken = 1'b0;
            we    = 1'b0;
        end
    end

    // One serial step moves min(SHIFT_STEP, remaining) bit positions
    always_comb begin
        step = (rem_q < STEP) ? rem_q : STEP;
        case (kind_q)
            SH_LL:   shifted = result_q << step;
            SH_RA:   shifted = $signed(result_q) >>> step;
            default: shifted = result_q >> step;
        endcase
    end

    assign ready  = !i_rst && !bus.i_flush &&
                    (state_q == IDLE || (state_q == HOLD && bus.i_ready));
    assign accept = bus.i_valid && ready;

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        valid_d   = valid_q;
        result_d  = result_q;
        rd_d      = rd_q;
        we_d      = we_q;
        taken_d   = taken_q;
        target_d  = target_q;
        wdata_d   = wdata_q;
        illegal_d = illegal_q;
        retired_d = retired_q;
        rem_d     = rem_q;

        case (state_q)
            SHIFT: begin
                result_d = shifted;
                rem_d    = rem_q - step;
                if (rem_q <= STEP) begin
                    state_d = HOLD;
                    valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (bus.i_ready) begin
                    retired_d = retired_q + 32'd1;
                    state_d   = IDLE;
                    valid_d   = 1'b0;
                end
            end
            default: ;
        endcase

        // A new op accepted in HOLD overwrites the retiring one in the same cycle
        if (accept) begin
            state_d   = serial ? SHIFT : HOLD;
            valid_d   = !serial;
            result_d  = serial ? bus.i_rs1 : alu;
            rem_d     = shamt;
            kind_d    = kind_dec;
            rd_d      = bus.i_rd;
            we_d      = we;
            taken_d   = taken;
            target_d  = target;
            wdata_d   = bus.i_rs2;
            illegal_d = illegal;
        end

        if (bus.i_flush) begin
            state_d   = IDLE;
            valid_d   = 1'b0;
            retired_d = retired_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            kind_q    <= SH_LL;
            valid_q   <= 1'b0;
            result_q  <= '0;
            rd_q      <= '0;
            we_q      <= 1'b0;
            taken_q   <= 1'b0;
            target_q  <= '0;
            wdata_q   <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
            we_q      <= we_d;
            taken_q   <= taken_d;
            target_q  <= target_d;
            wdata_q   <= wdata_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
            rem_q     <= rem_d;
        end
    end

    assign bus.o_ready     = ready;
    assign bus.o_valid     = valid_q;
    assign bus.o_result    = result_q;
    assign bus.o_rd        = rd_q;
    assign bus.o_we        = we_q;
    assign bus.o_br_taken  = taken_q;
    assign bus.o_br_target = target_q;
    assign bus.o_mem_wdata = wdata_q;
    assign bus.o_illegal   = illegal_q;
    assign bus.o_retired   = retired_q;
endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: expected outputs are queued at issue and
// checked when the stage presents them.
module tb_execute_stage;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned INST_W = 64;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        we;
        logic        taken;
        logic [31:0] target;
        logic [31:0] wdata;
        logic        illegal;
    } out_t;
    localparam int unsigned OW = $bits(out_t);

    typedef struct packed {
        out_t val;
        out_t mask;
        int   lat;
    } exp_t;

    typedef struct {
        logic [63:0] inst;
        logic [31:0] rs1, rs2, imm, pc;
        logic [4:0]  rd;
        exp_t        e;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    execute_stage_if #(.XLEN(XLEN), .INST_W(INST_W)) bus();

    execute_stage #(
        .XLEN(XLEN), .INST_W(INST_W), .SERIAL_SHIFT(1), .SHIFT_STEP(4)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus)
    );

    exp_t        sb[$];
    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] exp_retired = '0;
    out_t        got;
    exp_t        e;
    int          lat;

    function automatic logic [63:0] oh(input int unsigned b);
        return 64'd1 << b;
    endfunction

    function automatic op_t mkop(input logic [63:0] inst, input logic [31:0] rs1, rs2, imm, pc,
                                 input logic [4:0] rd, input logic [31:0] res, input bit chk_res,
                                 input logic we, taken, input logic [31:0] tgt, input bit chk_tgt,
                                 input logic [31:0] wd, input bit chk_wd, input logic ill,
                                 input int l);
        op_t o;
        o.inst = inst; o.rs1 = rs1; o.rs2 = rs2; o.imm = imm; o.pc = pc; o.rd = rd;
        o.e.val  = '{res, rd, we, taken, tgt, wd, ill};
        o.e.mask = '{{32{chk_res}}, 5'h1f, 1'b1, 1'b1, {32{chk_tgt}}, {32{chk_wd}}, 1'b1};
        o.e.lat  = l;
        return o;
    endfunction

    function automatic out_t observe();
        return {bus.o_result, bus.o_rd, bus.o_we, bus.o_br_taken, bus.o_br_target,
                bus.o_mem_wdata, bus.o_illegal};
    endfunction

    // Drive one op (called at a negedge) and return at the negedge after acceptance
    task automatic issue(input op_t o, input bit push);
        if (push) sb.push_back(o.e);
        bus.Single_Instruction_i = o.inst;
        bus.i_rs1 = o.rs1; bus.i_rs2 = o.rs2; bus.i_imm = o.imm;
        bus.i_pc = o.pc;   bus.i_rd = o.rd;
        bus.i_valid = 1'b1;
        #1;
        for (int i = 0; i < 50; i++) begin
            if (bus.o_ready === 1'b1) begin
                @(posedge clk);
                @(negedge clk);
                bus.i_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        bus.i_valid = 1'b0;
        vectors++; errors++;
        $display("FAIL accept_timeout: o_ready stayed low, required 1 within 50 cycles");
    endtask

    task automatic wait_out(output int l);
        l = 0;
        while (bus.o_valid !== 1'b1 && l < 50) begin
            @(negedge clk);
            l++;
        end
        if (bus.o_valid !== 1'b1) begin
            vectors++; errors++;
            $display("FAIL out_timeout: o_valid=%b, required 1 within 50 cycles", bus.o_valid);
        end
    endtask

    task automatic test_reset();
        bus.i_valid = 0; bus.Single_Instruction_i = '0; bus.i_rs1 = '0; bus.i_rs2 = '0;
        bus.i_imm = '0; bus.i_pc = '0; bus.i_rd = '0; bus.i_flush = 0; bus.i_ready = 1;
        @(negedge clk); @(negedge clk);
        vectors++;
        if ({bus.o_valid, bus.o_ready, observe(), bus.o_retired} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b ready=%b out=%h retired=%h, required all 0",
                     bus.o_valid, bus.o_ready, observe(), bus.o_retired);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.o_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b required 1", bus.o_ready);
        end
    endtask

    task automatic check_retired(input string name);
        @(negedge clk);
        vectors++;
        if (bus.o_retired !== exp_retired) begin
            errors++;
            $display("FAIL %s retired: got %0d required %0d", name, bus.o_retired, exp_retired);
        end
    endtask

    task automatic test_alu();
        op_t ops[$];
        ops.push_back(mkop(oh(1),  5, 7, 0, 0, 3, 12, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        ops.push_back(mkop(oh(2),  5, 7, 0, 0, 3, 32'hFFFFFFFE, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        ops.push_back(mkop(oh(1),  32'hFFFFFFFF, 1, 0, 0, 3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        ops.push_back(mkop(oh(12), 32'hFF00FF00, 0, 32'h0F0F0F0F, 0, 4, 32'hF00FF00F, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        ops.push_back(mkop(oh(9),  32'hFFFFFFFF, 1, 0, 0, 4, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        ops.push_back(mkop(oh(10), 32'hFFFFFFFF, 1, 0, 0, 4, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        ops.push_back(mkop(oh(19), 0, 0, 32'hFFFFFFFF, 0, 4, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        ops.push_back(mkop(oh(22), 32'h1000, 0, 32'h10, 0, 2, 32'h1010, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        ops.push_back(mkop(oh(27), 32'h2000, 32'hDEADBEEF, 32'hFFFFFFFC, 0, 0, 32'h1FFC, 1, 0, 0, 0, 0, 32'hDEADBEEF, 1, 0, 0));
        ops.push_back(mkop(oh(25), 32'h2000, 32'h55, 32'h1, 0, 6, 32'h2001, 1, 0, 0, 0, 0, 32'h55, 1, 0, 0));
        ops.push_back(mkop(oh(36), 0, 0, 32'h12345000, 0, 9, 32'h12345000, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        ops.push_back(mkop(oh(37), 0, 0, 32'h2000, 32'h1000, 9, 32'h3000, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        ops.push_back(mkop(oh(40), 1, 2, 3, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (ops[i]) begin
            issue(ops[i], 1);
            wait_out(lat);
            e = sb.pop_front(); got = observe();
            vectors++;
            if (lat !== e.lat) begin
                errors++; $display("FAIL alu[%0d] latency: got %0d required %0d", i, lat, e.lat);
            end
            vectors++;
            if ((OW'(got) & OW'(e.mask)) !== (OW'(e.val) & OW'(e.mask))) begin
                errors++; $display("FAIL alu[%0d] outputs: got %h required %h mask %h", i, got, e.val, e.mask);
            end
            exp_retired++;
        end
        check_retired("alu");
    endtask

    task automatic test_shift();
        op_t ops[$];
        ops.push_back(mkop(oh(8),  32'h80000000, 9, 0, 0, 5, 32'hFFC00000, 1, 1, 0, 0, 0, 0, 0, 0, 3));
        ops.push_back(mkop(oh(8),  32'h80000000, 0, 0, 0, 5, 32'h80000000, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        ops.push_back(mkop(oh(6),  1, 31, 0, 0, 5, 32'h80000000, 1, 1, 0, 0, 0, 0, 0, 0, 8));
        ops.push_back(mkop(oh(15), 1, 0, 8, 0, 5, 32'h100, 1, 1, 0, 0, 0, 0, 0, 0, 2));
        ops.push_back(mkop(oh(16), 32'hF0000000, 0, 4, 0, 5, 32'h0F000000, 1, 1, 0, 0, 0, 0, 0, 0, 1));
        ops.push_back(mkop(oh(17), 32'h80000010, 0, 32'h403, 0, 5, 32'hF0000002, 1, 1, 0, 0, 0, 0, 0, 0, 1));
        ops.push_back(mkop(oh(7),  3, 32'hFFFFFFE1, 0, 0, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1));
        foreach (ops[i]) begin
            issue(ops[i], 1);
            wait_out(lat);
            e = sb.pop_front(); got = observe();
            vectors++;
            if (lat !== e.lat) begin
                errors++; $display("FAIL shift[%0d] latency: got %0d required %0d", i, lat, e.lat);
            end
            vectors++;
            if ((OW'(got) & OW'(e.mask)) !== (OW'(e.val) & OW'(e.mask))) begin
                errors++; $display("FAIL shift[%0d] outputs: got %h required %h mask %h", i, got, e.val, e.mask);
            end
            exp_retired++;
        end
        check_retired("shift");
    endtask

    task automatic test_branch();
        op_t ops[$];
        ops.push_back(mkop(oh(32), 1, 32'hFFFFFFFF, 32'hFFFFFFF8, 32'h100, 7, 0, 0, 0, 1, 32'hF8, 1, 0, 0, 0, 0));
        ops.push_back(mkop(oh(30), 1, 32'hFFFFFFFF, 32'hFFFFFFF8, 32'h100, 7, 0, 0, 0, 0, 32'hF8, 1, 0, 0, 0, 0));
        ops.push_back(mkop(oh(28), 5, 5, 32'h10, 32'h200, 7, 0, 0, 0, 1, 32'h210, 1, 0, 0, 0, 0));
        ops.push_back(mkop(oh(29), 5, 5, 32'h10, 32'h200, 7, 0, 0, 0, 0, 32'h210, 1, 0, 0, 0, 0));
        ops.push_back(mkop(oh(31), 32'hFFFFFFFF, 32'hFFFFFFFF, 8, 32'h300, 7, 0, 0, 0, 1, 32'h308, 1, 0, 0, 0, 0));
        ops.push_back(mkop(oh(33), 1, 32'hFFFFFFFF, 32'hFFFFFFF8, 32'h100, 7, 0, 0, 0, 0, 32'hF8, 1, 0, 0, 0, 0));
        ops.push_back(mkop(oh(35), 32'h1001, 0, 2, 32'h40, 1, 32'h44, 1, 1, 1, 32'h1002, 1, 0, 0, 0, 0));
        ops.push_back(mkop(oh(34), 0, 0, 32'h20, 32'h80, 1, 32'h84, 1, 1, 1, 32'hA0, 1, 0, 0, 0, 0));
        ops.push_back(mkop(oh(34), 0, 0, 32'h20, 32'h80, 0, 32'h84, 1, 0, 1, 32'hA0, 1, 0, 0, 0, 0));
        foreach (ops[i]) begin
            issue(ops[i], 1);
            wait_out(lat);
            e = sb.pop_front(); got = observe();
            vectors++;
            if ((OW'(got) & OW'(e.mask)) !== (OW'(e.val) & OW'(e.mask))) begin
                errors++; $display("FAIL branch[%0d] outputs: got %h required %h mask %h", i, got, e.val, e.mask);
            end
            exp_retired++;
        end
        check_retired("branch");
    endtask

    task automatic test_illegal();
        op_t ops[$];
        ops.push_back(mkop(64'h6,  1, 2, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        ops.push_back(mkop(oh(38), 1, 2, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        ops.push_back(mkop(oh(11), 3, 0, 4, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        ops.push_back(mkop(oh(50), 1, 2, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        ops.push_back(mkop(64'h0,  1, 2, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        ops.push_back(mkop(oh(0),  1, 2, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        ops.push_back(mkop(oh(42), 1, 2, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        ops.push_back(mkop(oh(39), 1, 2, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        ops.push_back(mkop(oh(28) | oh(50), 5, 5, 8, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        foreach (ops[i]) begin
            issue(ops[i], 1);
            wait_out(lat);
            e = sb.pop_front(); got = observe();
            vectors++;
            if ((OW'(got) & OW'(e.mask)) !== (OW'(e.val) & OW'(e.mask))) begin
                errors++; $display("FAIL illegal[%0d] outputs: got %h required %h mask %h", i, got, e.val, e.mask);
            end
            exp_retired++;
        end
        check_retired("illegal");
    endtask

    task automatic test_back_to_back();
        op_t ops[$];
        ops.push_back(mkop(oh(1), 10, 20, 0, 0, 11, 30, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        ops.push_back(mkop(oh(4), 32'hF0, 32'h0F, 0, 0, 12, 32'hFF, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        ops.push_back(mkop(oh(5), 32'hF0, 32'h3C, 0, 0, 13, 32'h30, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        foreach (ops[i]) begin
            if (i > 0) begin
                vectors++;
                if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b1) begin
                    errors++; $display("FAIL b2b[%0d] hold_ready: got ready=%b valid=%b required 1 1",
                                       i, bus.o_ready, bus.o_valid);
                end
            end
            issue(ops[i], 1);
            wait_out(lat);
            e = sb.pop_front(); got = observe();
            vectors++;
            if (lat !== 0 || (OW'(got) & OW'(e.mask)) !== (OW'(e.val) & OW'(e.mask))) begin
                errors++; $display("FAIL b2b[%0d] outputs: lat %0d got %h required lat 0 %h", i, lat, got, e.val);
            end
            exp_retired++;
        end
        check_retired("b2b");
    endtask

    task automatic test_stall_flush_reset();
        op_t  add_op, srl_op;
        out_t snap;
        add_op = mkop(oh(1), 1, 2, 0, 0, 6, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        srl_op = mkop(oh(7), 32'hF0000000, 20, 0, 0, 8, 0, 0, 1, 0, 0, 0, 0, 0, 0, 5);

        bus.i_ready = 1'b0;
        issue(add_op, 1);
        wait_out(lat);
        e = sb.pop_front(); snap = observe();
        vectors++;
        if ((OW'(snap) & OW'(e.mask)) !== (OW'(e.val) & OW'(e.mask))) begin
            errors++; $display("FAIL stall outputs: got %h required %h", snap, e.val);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (observe() !== snap || bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0) begin
                errors++; $display("FAIL stall_hold[%0d]: got %h valid=%b ready=%b required %h valid=1 ready=0",
                                   i, observe(), bus.o_valid, bus.o_ready, snap);
            end
        end
        bus.i_ready = 1'b1;
        exp_retired++;
        check_retired("stall_release");

        issue(srl_op, 0);
        @(negedge clk);
        bus.i_flush = 1'b1;
        bus.Single_Instruction_i = add_op.inst; bus.i_valid = 1'b1;
        #1;
        vectors++;
        if (bus.o_ready !== 1'b0) begin
            errors++; $display("FAIL flush_ready: got %b required 0", bus.o_ready);
        end
        @(negedge clk);
        bus.i_flush = 1'b0; bus.i_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (bus.o_valid !== 1'b0) begin
                errors++; $display("FAIL flush_valid[%0d]: got %b required 0", i, bus.o_valid);
            end
            @(negedge clk);
        end
        vectors++;
        if (bus.o_retired !== exp_retired || bus.o_ready !== 1'b1) begin
            errors++; $display("FAIL flush_state: retired %0d ready %b required %0d 1",
                               bus.o_retired, bus.o_ready, exp_retired);
        end

        bus.i_ready = 1'b0;
        issue(add_op, 0);
        bus.i_ready = 1'b1; bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_flush = 1'b0;
        vectors++;
        if (bus.o_valid !== 1'b0 || bus.o_retired !== exp_retired) begin
            errors++; $display("FAIL flush_priority: valid %b retired %0d required 0 %0d",
                               bus.o_valid, bus.o_retired, exp_retired);
        end

        bus.i_ready = 1'b0;
        issue(add_op, 0);
        #2 rst = 1'b1;
        #1;
        exp_retired = '0;
        vectors++;
        if ({bus.o_valid, bus.o_ready, observe(), bus.o_retired} !== '0) begin
            errors++; $display("FAIL reset_mid_hold: valid=%b ready=%b out=%h retired=%h required all 0",
                               bus.o_valid, bus.o_ready, observe(), bus.o_retired);
        end
        @(negedge clk);
        rst = 1'b0; bus.i_ready = 1'b1;
        #1;
        vectors++;
        if (bus.o_ready !== 1'b1 || bus.o_retired !== 32'd0) begin
            errors++; $display("FAIL reset_recover: ready %b retired %0d required 1 0",
                               bus.o_ready, bus.o_retired);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_shift();
        test_branch();
        test_illegal();
        test_back_to_back();
        test_stall_flush_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Pipelined RV32I execute stage that consumes the decoder's one-hot instruction vector plus operands.
- Computes ALU result, branch decision and target, and memory address and write data.
- Registers all of these behind a valid/ready handshake.
- Sits between decode/register-read and memory/writeback.
- Adds a parametrised, optionally iterative (multi-cycle) shifter, flush, and a retire counter.

Parameters:
- XLEN, 32, datapath width (operands, results, PC).
- INST_W, 64, width of the one-hot instruction vector.
- SERIAL_SHIFT, 1. 1 selects an iterative shifter; 0 selects a single-cycle barrel shifter.
- SHIFT_STEP, 4, bit positions shifted per cycle in serial mode. Power of two, 1..16.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  upstream operation valid.
- o_ready  out  1  stage can accept an operation this cycle.
- Single_Instruction_i  in  INST_W  one-hot decoded instruction. Bit order: 0 UNKNOWN, 1 ADD, 2 SUB, 3 XOR, 4 OR, 5 AND, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU, 11 ADDI, 12 XORI, 13 ORI, 14 ANDI, 15 SLLI, 16 SRLI, 17 SRAI, 18 SLTI, 19 SLTIU, 20 LB, 21 LH, 22 LW, 23 LBU, 24 LHU, 25 SB, 26 SH, 27 SW, 28 BEQ, 29 BNE, 30 BLT, 31 BGE, 32 BLTU, 33 BGEU, 34 JAL, 35 JALR, 36 LUI, 37 AUIPC, 38 ECALL, 39 EBREAK, 40 FENCE, 41 FENCEI, 42-47 CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI. Bits 48+ are reserved.
- i_rs1, i_rs2  in  XLEN  register operands.
- i_imm  in  XLEN  sign-extended immediate.
- i_pc  in  XLEN  instruction PC.
- i_rd  in  5  destination register.
- i_flush  in  1  kill in-flight and held operations.
- i_ready  in  1  downstream accepts output.
- o_valid  out  1  outputs valid.
- o_result  out  XLEN  writeback value, or address for loads and stores.
- o_rd  out  5  destination register.
- o_we  out  1  register write enable.
- o_br_taken  out  1  redirect required.
- o_br_target  out  XLEN  redirect PC.
- o_mem_wdata  out  XLEN  store data (i_rs2).
- o_illegal  out  1  unsupported or malformed instruction.
- o_retired  out  32  count of operations handed downstream.

Behaviour:
- Reset (asynchronous, immediate): every output is 0, the FSM enters IDLE, and o_retired is 0.
- FSM states: IDLE, SHIFT, HOLD.
  - o_ready = (state==IDLE) || (state==HOLD && i_ready).
  - An operation is accepted on i_valid && o_ready.
- Non-shift operations, and all operations when SERIAL_SHIFT=0: registered into HOLD the cycle after acceptance, so latency is 1.
- Serial shift (SLL, SRL, SRA, SLLI, SRLI, SRAI with SERIAL_SHIFT=1):
  - shamt = operand2[4:0].
  - shamt==0 goes straight to HOLD.
  - Otherwise the stage enters SHIFT for ceil(shamt/SHIFT_STEP) cycles. Each cycle moves min(SHIFT_STEP, remaining) bits; SRA replicates the sign bit.
  - HOLD is entered after the last step. o_ready is 0 throughout SHIFT.
- HOLD:
  - o_valid=1 and all outputs are stable until i_ready.
  - On i_ready, o_retired increments (wrapping at 2^32 to 0).
  - The stage then either accepts a new operation in the same cycle or returns to IDLE.
- Operand 2 selection: i_imm for I-type ops, loads, stores, JALR and LUI; i_rs2 otherwise.
- Arithmetic:
  - Arithmetic is modulo 2^XLEN.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned.
  - LUI result = imm.
  - AUIPC result = pc+imm.
- Loads and stores: o_result = rs1+imm, o_mem_wdata = rs2. Loads set o_we; stores do not.
- Branches:
  - o_br_taken = compare result (BLT/BGE signed, BLTU/BGEU unsigned).
  - o_br_target = pc+imm. o_we=0.
- JAL and JALR:
  - o_result = pc+4, o_br_taken=1.
  - Target is pc+imm for JAL and (rs1+imm)&~1 for JALR.
- FENCE and FENCEI: no-op, o_we=0.
- Illegal: UNKNOWN, ECALL, EBREAK, CSR*, any reserved bit, a zero vector, or more than one bit set.
  - o_illegal=1, o_we=0, o_br_taken=0.
  - Still handshaken and counted.
- o_we is forced to 0 when rd==0.
- Flush:
  - i_flush forces the FSM to IDLE and clears o_valid next cycle, aborting any shift.
  - o_retired is unchanged.
  - An operation offered in the flush cycle is dropped; o_ready=0 during flush.
- Flush has priority over a simultaneous i_ready. Reset has priority over everything.

Test Plan:
- ADD, rs1=5, rs2=7, rd=3, i_ready=1 -> one cycle later o_valid=1, o_result=12, o_we=1, o_retired=1.
- SRA with SERIAL_SHIFT=1, STEP=4, rs1=0x80000000, rs2=9 -> o_ready low for 3 cycles, then o_result=0xFFC00000. Repeat with shamt=0 -> latency 1.
- BLTU, rs1=1, rs2=0xFFFFFFFF, pc=0x100, imm=-8 -> o_br_taken=1, o_br_target=0xF8. Same operands on BLT -> o_br_taken=0.
- JALR, rs1=0x1001, imm=2, pc=0x40, rd=1 -> o_result=0x44, o_br_target=0x1002, o_br_taken=1.
- Vector with bits 1 and 2 set, then ECALL, then ADDI with rd=0 -> o_illegal=1 for the first two and o_we=0 for all three. o_retired=3.
- i_ready=0 for 4 cycles while HOLD, then i_flush mid-SRL shift, then i_rst asserted mid-HOLD -> outputs stable while stalled, flush clears o_valid next cycle, reset zeroes all outputs immediately.
